// File: rtl/pixel_rate_encoder.sv
// pixel_rate_encoder: streams the 24x24 image out of the image SPBRAM and
// turns it into one timestep of Poisson-like spikes, one 24-bit row bundle
// every 6 cycles, by comparing each pixel against a byte of a 32-bit Galois LFSR.
// Optional feature macro: ENC_SPIKE_CNT_EN adds o_spike_cnt (total spikes per timestep).
module pixel_rate_encoder #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned ROW_PIX   = 24,
  parameter int unsigned ROWS      = 24,
  parameter int unsigned WORDS     = 144,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run,
  input  logic               i_clr,
  output logic               o_ce,
  output logic [7:0]         o_addr,
  input  logic [31:0]        i_rdata,
  output logic               o_valid,
  output logic [4:0]         o_row,
  output logic [ROW_PIX-1:0] o_spike_bundle,
  output logic               o_busy,
  output logic               o_done
`ifdef ENC_SPIKE_CNT_EN
  ,output logic [9:0]        o_spike_cnt
`endif
);

  localparam int unsigned PPW = 4;              // pixels per BRAM word
  localparam int unsigned WPR = ROW_PIX / PPW;  // words per row

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FLUSH} state_t;

  state_t             r_state;
  logic               r_cap;
  logic [2:0]         r_cw;
  logic [4:0]         r_crow;
  logic [ROW_PIX-1:0] r_asm;
  logic [31:0]        r_lfsr;

  logic [PPW-1:0]     w_spk;
  logic [ROW_PIX-1:0] w_asm_nxt;
  logic [31:0]        w_lfsr_nxt;

  // Per-pixel strict compare against the matching LFSR byte, plus next LFSR state
  always_comb begin
    w_spk = '0;
    for (int j = 0; j < PPW; j++) begin
      w_spk[j] = (i_rdata[j*PIX_W +: PIX_W] > r_lfsr[j*PIX_W +: PIX_W]);
    end
    w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);
  end

  // Drop the four new spikes into their column slot of the row assembly register
  always_comb begin
    w_asm_nxt = r_asm;
    for (int c = 0; c < WPR; c++) begin
      if (r_cw == 3'(c)) begin
        w_asm_nxt[c*PPW +: PPW] = w_spk;
      end
    end
  end

`ifdef ENC_SPIKE_CNT_EN
  logic [2:0] w_spk_sum;

  // Popcount of the four spikes captured this cycle
  always_comb begin
    w_spk_sum = 3'(w_spk[0]) + 3'(w_spk[1]) + 3'(w_spk[2]) + 3'(w_spk[3]);
  end
`endif

  // Controller FSM, BRAM address stream, word capture and row emission
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      o_ce           <= 1'b0;
      o_addr         <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_valid        <= 1'b0;
      o_row          <= '0;
      o_spike_bundle <= '0;
      r_cap          <= 1'b0;
      r_cw           <= '0;
      r_crow         <= '0;
      r_asm          <= '0;
      r_lfsr         <= LFSR_SEED;
`ifdef ENC_SPIKE_CNT_EN
      o_spike_cnt    <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_done  <= 1'b0;
      if (i_clr) begin
        r_state        <= S_IDLE;
        o_ce           <= 1'b0;
        o_addr         <= '0;
        o_busy         <= 1'b0;
        o_row          <= '0;
        o_spike_bundle <= '0;
        r_cap          <= 1'b0;
        r_cw           <= '0;
        r_crow         <= '0;
        r_asm          <= '0;
        r_lfsr         <= LFSR_SEED;
`ifdef ENC_SPIKE_CNT_EN
        o_spike_cnt    <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_run) begin
              r_state <= S_FETCH;
              o_ce    <= 1'b1;
              o_addr  <= '0;
              o_busy  <= 1'b1;
              r_cw    <= '0;
              r_crow  <= '0;
`ifdef ENC_SPIKE_CNT_EN
              o_spike_cnt <= '0;
`endif
            end
          end
          S_FETCH: begin
            if (o_addr == 8'(WORDS - 1)) begin
              r_state <= S_DRAIN;
              o_ce    <= 1'b0;
            end else begin
              o_addr  <= o_addr + 8'd1;
            end
          end
          S_DRAIN: begin
            r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase

        // BRAM data is valid the cycle after each enabled read
        r_cap <= o_ce;
        if (r_cap) begin
          r_lfsr <= w_lfsr_nxt;
          r_asm  <= w_asm_nxt;
`ifdef ENC_SPIKE_CNT_EN
          o_spike_cnt <= o_spike_cnt + 10'(w_spk_sum);
`endif
          if (r_cw == 3'(WPR - 1)) begin
            r_cw           <= '0;
            o_valid        <= 1'b1;
            o_row          <= r_crow;
            o_spike_bundle <= w_asm_nxt;
            r_crow         <= (r_crow == 5'(ROWS - 1)) ? 5'd0 : r_crow + 5'd1;
          end else begin
            r_cw <= r_cw + 3'd1;
          end
        end
      end
    end
  end

endmodule
